pwm_ctrl: RTL

PWM_CTRL -- requirements
Module: pwm_ctrl

---
 rtl/pwm_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pwm_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_ctrl : two-channel PWM generator fed from an I2C register file.
//
// Ports
//   clock             system clock (the divided clock shared with the I2C slave)
//   reset_n           asynchronous active-low reset, released synchronously
//   registers_packed  register file contents:
//                       [7:0]   CTRL  : bit0 EN0, bit1 EN1, bit2 INV0,
//                                       bit3 INV1, bits[7:4] PRESC
//                       [15:8]  TOP   : last value of the period counter
//                       [23:16] DUTY0 : channel 0 compare value
//                       [31:24] DUTY1 : channel 1 compare value
//   pwm               registered PWM outputs, bit n = channel n
//   period_tick       one-clock pulse on the edge where the counter wraps to 0
//   cnt_out           current period counter value
//
// TOP and DUTYn are shadowed and only picked up when the counter wraps, so
// register writes in the middle of a period can never glitch an output.
// EN and INV are used live. NUM_CH and CNT_W are fixed at 2 and 8 by the
// register map layout.
// ---------------------------------------------------------------------------
module pwm_ctrl #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       registers_packed,
    output logic [NUM_CH-1:0] pwm,
    output logic              period_tick,
    output logic [CNT_W-1:0]  cnt_out
);

    // Live register fields
    logic [NUM_CH-1:0] ctrl_en;
    logic [NUM_CH-1:0] ctrl_inv;
    logic [3:0]        ctrl_presc;
    logic [CNT_W-1:0]  reg_top;
    logic [CNT_W-1:0]  reg_duty [NUM_CH];

    assign ctrl_en    = registers_packed[NUM_CH-1:0];
    assign ctrl_inv   = registers_packed[2 +: NUM_CH];
    assign ctrl_presc = registers_packed[7:4];
    assign reg_top    = registers_packed[8 +: CNT_W];

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            reg_duty[n] = registers_packed[16 + 8*n +: CNT_W];
        end
    end

    // State
    logic [3:0]        presc_q;      // prescaler count, 0..presc_s_q
    logic [3:0]        presc_s_q;    // PRESC latched at each prescaler wrap
    logic [CNT_W-1:0]  cnt_q;        // period counter
    logic [CNT_W-1:0]  top_s_q;      // shadow TOP
    logic [CNT_W-1:0]  duty_s_q [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;
    logic              period_tick_q;

    logic              any_en;
    logic              tick;
    logic              wrap;
    logic [NUM_CH-1:0] raw;

    assign any_en = |ctrl_en;
    assign tick   = (presc_q == presc_s_q);
    // ">=" rather than "==" so the counter can never run past TOP_s even if
    // the shadow were ever below the count.
    assign wrap   = tick && (cnt_q >= top_s_q);

    // DUTY = 0 never matches, DUTY > TOP always matches: 0% and 100% fall
    // out of the plain unsigned compare with no special cases.
    always_comb begin
        raw = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            raw[n] = (cnt_q < duty_s_q[n]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q       <= '0;
            presc_s_q     <= '0;
            cnt_q         <= '0;
            top_s_q       <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_s_q[n] <= '0;
            end
            pwm_q         <= '0;
            period_tick_q <= 1'b0;
        end else begin
            // Output stage uses the counter value present before this edge.
            pwm_q <= (raw & ctrl_en) ^ ctrl_inv;

            if (!any_en) begin
                // Idle: hold counters at 0 and track the registers every
                // clock so enabling starts from the current values.
                presc_q       <= '0;
                presc_s_q     <= ctrl_presc;
                cnt_q         <= '0;
                top_s_q       <= reg_top;
                for (int n = 0; n < NUM_CH; n++) begin
                    duty_s_q[n] <= reg_duty[n];
                end
                period_tick_q <= 1'b0;
            end else begin
                period_tick_q <= wrap;
                if (tick) begin
                    presc_q   <= '0;
                    presc_s_q <= ctrl_presc;
                    if (wrap) begin
                        cnt_q   <= '0;
                        top_s_q <= reg_top;
                        for (int n = 0; n < NUM_CH; n++) begin
                            duty_s_q[n] <= reg_duty[n];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    assign pwm         = pwm_q;
    assign period_tick = period_tick_q;
    assign cnt_out     = cnt_q;

endmodule
